// File: rtl/l2_task_ready_queue.sv
// ---------------------------------------------------------------------------
// l2_task_ready_queue
//
// Dependency tracker and ready queue for the L2 scheduler. Every (dag, task)
// slot holds an armed bit and a pending-input counter. A slot whose counter
// drains to zero (or that is armed with zero inputs) is pushed into a ready
// FIFO. The FIFO head is offered to the task manager via a fire handshake.
// An ack pops the head. A nack rotates the head to the tail.
//
// Optional feature macro: L2_READY_QUEUE_STATS_EN
//   Adds stat_nack_cnt (saturating nack counter) and stat_max_occupancy
//   (ready_count high-water mark) output ports.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   init_valid/ready      arm slot (init_dag_id, init_task_id, init_input_num)
//   done_valid/ready      one input of (done_dag_id, done_task_id) arrived
//   fire_valid            head of ready queue presented (fire_dag_id/task_id)
//   fire_ack, fire_nack   task manager accepts / refuses the head
//   ready_count           queue occupancy
//   err_underflow         sticky: done on an unarmed slot
//   err_overrange         sticky: init_input_num > MAX_INPUTS
//   err_acknack           sticky: ack and nack together on a valid head
// ---------------------------------------------------------------------------
module l2_task_ready_queue #(
  parameter int NUM_DAG       = 4,
  parameter int TASKS_PER_DAG = 64,
  parameter int MAX_INPUTS    = 4,
  parameter int FIFO_DEPTH    = 16,
  localparam int DW = (NUM_DAG > 1) ? $clog2(NUM_DAG) : 1,
  localparam int TW = $clog2(TASKS_PER_DAG),
  localparam int CW = $clog2(MAX_INPUTS) + 1,
  localparam int PW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init_valid,
  input  logic [DW-1:0] init_dag_id,
  input  logic [TW-1:0] init_task_id,
  input  logic [CW-1:0] init_input_num,
  output logic          init_ready,
  input  logic          done_valid,
  input  logic [DW-1:0] done_dag_id,
  input  logic [TW-1:0] done_task_id,
  output logic          done_ready,
  output logic          fire_valid,
  output logic [DW-1:0] fire_dag_id,
  output logic [TW-1:0] fire_task_id,
  input  logic          fire_ack,
  input  logic          fire_nack,
  output logic [PW-1:0] ready_count,
  output logic          err_underflow,
  output logic          err_overrange,
  output logic          err_acknack
`ifdef L2_READY_QUEUE_STATS_EN
  ,
  output logic [15:0]   stat_nack_cnt,
  output logic [PW-1:0] stat_max_occupancy
`endif
);

  localparam int AW    = PW - 1;
  localparam int NSLOT = NUM_DAG * TASKS_PER_DAG;
  localparam int SW    = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int EW    = DW + TW;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_INPUTS);
  localparam logic [CW-1:0] ONE_CNT = CW'(1);
  localparam logic [PW-1:0] DEPTH_C = PW'(FIFO_DEPTH);

  // Slot table
  logic          slot_armed_q [NSLOT];
  logic          slot_armed_d [NSLOT];
  logic [CW-1:0] slot_cnt_q   [NSLOT];
  logic [CW-1:0] slot_cnt_d   [NSLOT];

  // Ready FIFO; pointers carry an extra wrap bit
  logic [EW-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [EW-1:0] fifo_mem_d [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;

  logic err_underflow_q, err_underflow_d;
  logic err_overrange_q, err_overrange_d;
  logic err_acknack_q,   err_acknack_d;

  logic [PW-1:0] count;
  logic          empty, full, space;
  logic          pop, rot;
  logic          init_fire, done_fire;
  logic          push;
  logic [EW-1:0] push_data;
  logic [EW-1:0] head;
  logic [SW-1:0] init_idx, done_idx;

  assign count = wptr_q - rptr_q;
  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);
  assign head  = fifo_mem_q[rptr_q[AW-1:0]];

  assign pop   = !empty && fire_ack;
  // A nack rotates the head through the push port, so slot ops must stall.
  assign rot   = !empty && fire_nack && !fire_ack;
  assign space = !full || pop;

  assign init_ready = space && !rot;
  assign done_ready = !init_valid && space && !rot;
  assign init_fire  = init_valid && init_ready;
  assign done_fire  = done_valid && done_ready;

  assign init_idx = SW'(init_dag_id) * SW'(TASKS_PER_DAG) + SW'(init_task_id);
  assign done_idx = SW'(done_dag_id) * SW'(TASKS_PER_DAG) + SW'(done_task_id);

  assign fire_valid   = !empty;
  // Zero the id outputs when idle: the FIFO array itself is never reset.
  assign fire_dag_id  = empty ? '0 : head[EW-1:TW];
  assign fire_task_id = empty ? '0 : head[TW-1:0];
  assign ready_count  = count;

  assign err_underflow = err_underflow_q;
  assign err_overrange = err_overrange_q;
  assign err_acknack   = err_acknack_q;

  always_comb begin
    slot_armed_d    = slot_armed_q;
    slot_cnt_d      = slot_cnt_q;
    fifo_mem_d      = fifo_mem_q;
    wptr_d          = wptr_q;
    rptr_d          = rptr_q;
    err_underflow_d = err_underflow_q;
    err_overrange_d = err_overrange_q;
    err_acknack_d   = err_acknack_q || (!empty && fire_ack && fire_nack);
    push            = 1'b0;
    push_data       = '0;

    if (init_fire) begin
      if (init_input_num == '0) begin
        slot_armed_d[init_idx] = 1'b0;
        slot_cnt_d[init_idx]   = '0;
        push                   = 1'b1;
        push_data              = {init_dag_id, init_task_id};
      end else if (init_input_num > MAX_CNT) begin
        err_overrange_d        = 1'b1;
        slot_armed_d[init_idx] = 1'b1;
        slot_cnt_d[init_idx]   = MAX_CNT;
      end else begin
        slot_armed_d[init_idx] = 1'b1;
        slot_cnt_d[init_idx]   = init_input_num;
      end
    end else if (done_fire) begin
      if (!slot_armed_q[done_idx]) begin
        err_underflow_d = 1'b1;
      end else if (slot_cnt_q[done_idx] == ONE_CNT) begin
        slot_armed_d[done_idx] = 1'b0;
        slot_cnt_d[done_idx]   = '0;
        push                   = 1'b1;
        push_data              = {done_dag_id, done_task_id};
      end else begin
        slot_cnt_d[done_idx] = slot_cnt_q[done_idx] - ONE_CNT;
      end
    end

    if (rot) begin
      push      = 1'b1;
      push_data = head;
    end

    if (push) begin
      fifo_mem_d[wptr_q[AW-1:0]] = push_data;
      wptr_d                     = wptr_q + PW'(1);
    end
    if (pop || rot) begin
      rptr_d = rptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NSLOT; i++) begin
        slot_armed_q[i] <= 1'b0;
        slot_cnt_q[i]   <= '0;
      end
      wptr_q          <= '0;
      rptr_q          <= '0;
      err_underflow_q <= 1'b0;
      err_overrange_q <= 1'b0;
      err_acknack_q   <= 1'b0;
    end else begin
      slot_armed_q    <= slot_armed_d;
      slot_cnt_q      <= slot_cnt_d;
      wptr_q          <= wptr_d;
      rptr_q          <= rptr_d;
      err_underflow_q <= err_underflow_d;
      err_overrange_q <= err_overrange_d;
      err_acknack_q   <= err_acknack_d;
    end
  end

  // FIFO storage is data only; validity comes from the pointers.
  always_ff @(posedge clk) begin
    fifo_mem_q <= fifo_mem_d;
  end

`ifdef L2_READY_QUEUE_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0]   stat_nack_cnt_q, stat_nack_cnt_d;
  logic [PW-1:0] stat_max_occ_q,  stat_max_occ_d;
  logic [PW-1:0] count_next;

  assign count_next = wptr_d - rptr_d;

  always_comb begin
    stat_nack_cnt_d = rot ? sat_inc16(stat_nack_cnt_q) : stat_nack_cnt_q;
    // Track the post-update occupancy so the mark never trails ready_count.
    stat_max_occ_d  = (count_next > stat_max_occ_q) ? count_next : stat_max_occ_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_nack_cnt_q <= '0;
      stat_max_occ_q  <= '0;
    end else begin
      stat_nack_cnt_q <= stat_nack_cnt_d;
      stat_max_occ_q  <= stat_max_occ_d;
    end
  end

  assign stat_nack_cnt      = stat_nack_cnt_q;
  assign stat_max_occupancy = stat_max_occ_q;
`endif

endmodule

// File: tb/tb_l2_task_ready_queue.sv
// ---------------------------------------------------------------------------
// Testbench for l2_task_ready_queue: directed scenarios plus randomized
// traffic, checked every cycle against a queue/array reference model.
// ---------------------------------------------------------------------------
module tb_l2_task_ready_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       init_valid;
  logic [1:0] init_dag_id;
  logic [5:0] init_task_id;
  logic [2:0] init_input_num;
  logic       init_ready;
  logic       done_valid;
  logic [1:0] done_dag_id;
  logic [5:0] done_task_id;
  logic       done_ready;
  logic       fire_valid;
  logic [1:0] fire_dag_id;
  logic [5:0] fire_task_id;
  logic       fire_ack;
  logic       fire_nack;
  logic [4:0] ready_count;
  logic       err_underflow;
  logic       err_overrange;
  logic       err_acknack;

  l2_task_ready_queue dut (
    .clk            (clk),
    .rst            (rst),
    .init_valid     (init_valid),
    .init_dag_id    (init_dag_id),
    .init_task_id   (init_task_id),
    .init_input_num (init_input_num),
    .init_ready     (init_ready),
    .done_valid     (done_valid),
    .done_dag_id    (done_dag_id),
    .done_task_id   (done_task_id),
    .done_ready     (done_ready),
    .fire_valid     (fire_valid),
    .fire_dag_id    (fire_dag_id),
    .fire_task_id   (fire_task_id),
    .fire_ack       (fire_ack),
    .fire_nack      (fire_nack),
    .ready_count    (ready_count),
    .err_underflow  (err_underflow),
    .err_overrange  (err_overrange),
    .err_acknack    (err_acknack)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model
  typedef struct { int d; int t; } ent_t;
  ent_t m_q[$];
  bit   m_armed [4][64];
  int   m_cnt   [4][64];
  bit   m_eu, m_eo, m_ea;

  function automatic void chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_q.delete();
    for (int d = 0; d < 4; d++)
      for (int t = 0; t < 64; t++) begin
        m_armed[d][t] = 1'b0;
        m_cnt[d][t]   = 0;
      end
    m_eu = 0; m_eo = 0; m_ea = 0;
  endfunction

  task automatic drive(input bit r, input bit iv, input int id, input int it, input int in_,
                       input bit dv, input int dd, input int dt, input bit ack, input bit nack);
    rst            = r;
    init_valid     = iv;
    init_dag_id    = id[1:0];
    init_task_id   = it[5:0];
    init_input_num = in_[2:0];
    done_valid     = dv;
    done_dag_id    = dd[1:0];
    done_task_id   = dt[5:0];
    fire_ack       = ack;
    fire_nack      = nack;
  endtask

  // One clock: drive, compare at the falling edge, advance the model.
  task automatic step(input bit r, input bit iv, input int id, input int it, input int in_,
                      input bit dv, input int dd, input int dt, input bit ack, input bit nack);
    int  occ;
    bit  e_fv, e_space, e_rot, e_ir, e_dr;
    ent_t h;
    drive(r, iv, id, it, in_, dv, dd, dt, ack, nack);
    @(negedge clk);
    occ     = m_q.size();
    e_fv    = (occ > 0);
    e_rot   = e_fv && nack && !ack;
    e_space = (occ < 16) || (e_fv && ack);
    e_ir    = e_space && !e_rot;
    e_dr    = e_space && !e_rot && !iv;
    chk("fire_valid",   fire_valid,   e_fv);
    chk("fire_dag_id",  fire_dag_id,  e_fv ? m_q[0].d : 0);
    chk("fire_task_id", fire_task_id, e_fv ? m_q[0].t : 0);
    chk("ready_count",  ready_count,  occ);
    chk("init_ready",   init_ready,   e_ir);
    chk("done_ready",   done_ready,   e_dr);
    chk("err_underflow", err_underflow, m_eu);
    chk("err_overrange", err_overrange, m_eo);
    chk("err_acknack",   err_acknack,   m_ea);
    if (r) begin
      model_reset();
    end else begin
      if (e_fv) begin
        if (ack && nack) m_ea = 1;
        if (ack) void'(m_q.pop_front());
        else if (nack) begin
          h = m_q.pop_front();
          m_q.push_back(h);
        end
      end
      if (iv && e_ir) begin
        if (in_ == 0) begin
          m_armed[id][it] = 0; m_cnt[id][it] = 0;
          m_q.push_back('{id, it});
        end else if (in_ > 4) begin
          m_eo = 1; m_armed[id][it] = 1; m_cnt[id][it] = 4;
        end else begin
          m_armed[id][it] = 1; m_cnt[id][it] = in_;
        end
      end else if (dv && e_dr) begin
        if (!m_armed[dd][dt]) m_eu = 1;
        else begin
          m_cnt[dd][dt]--;
          if (m_cnt[dd][dt] == 0) begin
            m_armed[dd][dt] = 0;
            m_q.push_back('{dd, dt});
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int ackp, nackp;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Reset state
    chk("rst_fire_valid", fire_valid, 0);
    chk("rst_count", ready_count, 0);
    chk("rst_dag", fire_dag_id, 0);
    chk("rst_errs", {err_underflow, err_overrange, err_acknack}, 0);
    chk("rst_init_ready", init_ready, 1);
    chk("rst_done_ready", done_ready, 1);

    // Basic counting slot
    step(0, 1, 1, 5, 2, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 5, 0, 0);
    chk("t1_not_ready", fire_valid, 0);
    step(0, 0, 0, 0, 0, 1, 1, 5, 0, 0);
    chk("t1_fv", fire_valid, 1);
    chk("t1_dag", fire_dag_id, 1);
    chk("t1_task", fire_task_id, 5);
    chk("t1_count", ready_count, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("t1_count_ack", ready_count, 0);

    // Nack rotation
    step(0, 1, 0, 3, 0, 0, 0, 0, 0, 0);
    step(0, 1, 2, 7, 0, 0, 0, 0, 0, 0);
    chk("t2_head0", {fire_dag_id, fire_task_id}, {2'd0, 6'd3});
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("t2_head1", {fire_dag_id, fire_task_id}, {2'd2, 6'd7});
    chk("t2_count", ready_count, 2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("t2_head2", {fire_dag_id, fire_task_id}, {2'd0, 6'd3});
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("t2_empty", fire_valid, 0);

    // Full queue
    for (int i = 0; i < 16; i++) step(0, 1, 0, i, 0, 0, 0, 0, 0, 0);
    chk("t3_count16", ready_count, 16);
    drive(0, 1, 0, 20, 0, 1, 0, 1, 0, 0);
    #1;
    chk("t3_init_ready_full", init_ready, 0);
    chk("t3_done_ready_full", done_ready, 0);
    drive(0, 1, 0, 20, 0, 0, 0, 0, 1, 0);
    #1;
    chk("t3_init_ready_pop", init_ready, 1);
    step(0, 1, 0, 20, 0, 0, 0, 0, 1, 0);
    chk("t3_count_still16", ready_count, 16);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("t3_drained", ready_count, 0);

    // Underflow and overrange
    step(0, 0, 0, 0, 0, 1, 3, 63, 0, 0);
    chk("t4_underflow", err_underflow, 1);
    chk("t4_fv", fire_valid, 0);
    step(0, 1, 3, 9, 5, 0, 0, 0, 0, 0);
    chk("t4_overrange", err_overrange, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 3, 9, 0, 0);
    chk("t4_not_yet", fire_valid, 0);
    step(0, 0, 0, 0, 0, 1, 3, 9, 0, 0);
    chk("t4_fired", {fire_valid, fire_dag_id, fire_task_id}, {1'b1, 2'd3, 6'd9});
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

    // init/done collision, ack&&nack
    drive(0, 1, 0, 1, 1, 1, 0, 1, 0, 0);
    #1;
    chk("t5_done_stall", done_ready, 0);
    step(0, 1, 0, 1, 1, 1, 0, 1, 0, 0);
    chk("t5_armed_only", fire_valid, 0);
    step(0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    chk("t5_fired", fire_valid, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("t5_popped", ready_count, 0);
    chk("t5_acknack", err_acknack, 1);

    // Reset mid-operation
    for (int i = 0; i < 3; i++) step(0, 1, 2, 30 + i, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 2, 3, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t6_fv", fire_valid, 0);
    chk("t6_count", ready_count, 0);
    chk("t6_errs", {err_underflow, err_overrange, err_acknack}, 0);
    step(0, 0, 0, 0, 0, 1, 1, 2, 0, 0);
    chk("t6_underflow", err_underflow, 1);

    // Randomized traffic
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    ackp = 50; nackp = 20;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) begin
        ackp  = $urandom_range(5, 90);
        nackp = $urandom_range(0, 40);
      end
      step(($urandom_range(0, 999) == 0),
           ($urandom_range(0, 99) < 40), $urandom_range(0, 3),
           ($urandom_range(0, 15) == 0) ? 63 : $urandom_range(0, 7), $urandom_range(0, 6),
           ($urandom_range(0, 99) < 60), $urandom_range(0, 3),
           ($urandom_range(0, 15) == 0) ? 63 : $urandom_range(0, 7),
           ($urandom_range(0, 99) < ackp), ($urandom_range(0, 99) < nackp));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
